contador_hora: RTL

//  Time-of-day source for the 6-digit multiplexed display: keeps HH:MM:SS as six BCD digits.

---
 rtl/contador_hora_if.sv | 28 ++
 rtl/contador_hora.sv | 138 +++++++++++++
 2 files changed

// File: rtl/contador_hora_if.sv
// Control pulses and BCD time/scan outputs shared between the time-of-day counter
// and the display path.
interface contador_hora_if;
    logic       run_en;
    logic       inc_min;
    logic       inc_hora;
    logic       clr_seg;
    logic [3:0] segundo1;
    logic [3:0] segundo2;
    logic [3:0] minuto1;
    logic [3:0] minuto2;
    logic [3:0] hora1;
    logic [3:0] hora2;
    logic [2:0] refreshcounter;
    logic       tick_1hz;

    modport master (
        output run_en, inc_min, inc_hora, clr_seg,
        input  segundo1, segundo2, minuto1, minuto2, hora1, hora2,
        input  refreshcounter, tick_1hz
    );

    modport slave (
        input  run_en, inc_min, inc_hora, clr_seg,
        output segundo1, segundo2, minuto1, minuto2, hora1, hora2,
        output refreshcounter, tick_1hz
    );
endinterface

// File: rtl/contador_hora.sv
// HH:MM:SS time-of-day counter in per-digit BCD with set-mode adjust, plus the
// free-running digit-scan index for the 6-digit multiplexed display.
module contador_hora #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int REFRESH_DIV = 100_000
) (
    input  logic           clk,
    input  logic           rst_n,
    contador_hora_if.slave bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0] REFDIV_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [2:0] SCAN_LAST = 3'd5;

    typedef struct packed {
        logic [3:0] h2;
        logic [3:0] h1;
        logic [3:0] m2;
        logic [3:0] m1;
        logic [3:0] s2;
        logic [3:0] s1;
    } hms_t;

    hms_t          time_q, time_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [RW-1:0] refdiv_q, refdiv_d;
    logic [2:0]    scan_q, scan_d;
    logic          tick_q, tick_d;

    logic sec_evt;
    logic set_min;
    logic set_hora;
    logic min_carry;
    logic hour_carry;

    // Clearing the seconds swallows a second that would have fired in the same cycle.
    assign sec_evt  = bus.run_en && (presc_q == PRESC_LAST) && !bus.clr_seg;
    assign set_min  = !bus.run_en && bus.inc_min;
    assign set_hora = !bus.run_en && bus.inc_hora;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        time_d     = time_q;
        presc_d    = presc_q;
        tick_d     = sec_evt;
        min_carry  = 1'b0;
        hour_carry = 1'b0;

        if (bus.clr_seg) begin
            presc_d = '0;
        end else if (bus.run_en) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end

        if (bus.clr_seg) begin
            time_d.s1 = 4'd0;
            time_d.s2 = 4'd0;
        end else if (sec_evt) begin
            if (time_q.s1 == 4'd9) begin
                time_d.s1 = 4'd0;
                if (time_q.s2 == 4'd5) begin
                    time_d.s2 = 4'd0;
                    min_carry = 1'b1;
                end else begin
                    time_d.s2 = time_q.s2 + 4'd1;
                end
            end else begin
                time_d.s1 = time_q.s1 + 4'd1;
            end
        end

        // A manual minute step wraps 59->00 without touching the hours.
        if (min_carry || set_min) begin
            if (time_q.m1 == 4'd9) begin
                time_d.m1 = 4'd0;
                if (time_q.m2 == 4'd5) begin
                    time_d.m2  = 4'd0;
                    hour_carry = min_carry;
                end else begin
                    time_d.m2 = time_q.m2 + 4'd1;
                end
            end else begin
                time_d.m1 = time_q.m1 + 4'd1;
            end
        end

        if (hour_carry || set_hora) begin
            if (time_q.h2 == 4'd2 && time_q.h1 == 4'd3) begin
                time_d.h2 = 4'd0;
                time_d.h1 = 4'd0;
            end else if (time_q.h1 == 4'd9) begin
                time_d.h1 = 4'd0;
                time_d.h2 = time_q.h2 + 4'd1;
            end else begin
                time_d.h1 = time_q.h1 + 4'd1;
            end
        end
    end

    always_comb begin
        refdiv_d = refdiv_q + 1'b1;
        scan_d   = scan_q;
        if (refdiv_q == REFDIV_LAST) begin
            refdiv_d = '0;
            scan_d   = (scan_q == SCAN_LAST) ? 3'd0 : scan_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values together.
        if (!rst_n) begin
            time_q   <= '0;
            presc_q  <= '0;
            refdiv_q <= '0;
            scan_q   <= 3'd0;
            tick_q   <= 1'b0;
        end else begin
            time_q   <= time_d;
            presc_q  <= presc_d;
            refdiv_q <= refdiv_d;
            scan_q   <= scan_d;
            tick_q   <= tick_d;
        end
    end

    assign bus.segundo1       = time_q.s1;
    assign bus.segundo2       = time_q.s2;
    assign bus.minuto1        = time_q.m1;
    assign bus.minuto2        = time_q.m2;
    assign bus.hora1          = time_q.h1;
    assign bus.hora2          = time_q.h2;
    assign bus.refreshcounter = scan_q;
    assign bus.tick_1hz       = tick_q;

endmodule
